pulse_sequencer: RTL and testbench
==================================

Name: pulse_sequencer

Overview:
- Plays a programmed list of mark/space symbols on a single output pin.
- Each symbol has an output level and a duration counted in prescaled ticks.
- Marks are optionally modulated by an internal 50%-duty carrier generator.
- Sits between the peripheral register interface (symbol memory writes, config, start/stop) and the transmit pin; it sequences and gates the carrier datapath.

Parameters:
- TIMER_WIDTH, 11, width of the carrier half-period count passed to the carrier generator.
- DURATION_WIDTH, 8, width of the per-symbol duration field.
- PRESCALE_WIDTH, 8, width of the tick prescaler.
- DEPTH, 8, number of symbol memory entries; power of two; ADDR_W = clog2(DEPTH).

Ports:
- clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- wr_en  in  1  symbol memory write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DURATION_WIDTH+1  {level, duration}; MSB is the level
- sym_count  in  ADDR_W+1  number of symbols to play
- loop_count  in  8  extra repetitions of the whole list
- prescale  in  PRESCALE_WIDTH  one tick every prescale+1 clocks
- carrier_duration  in  TIMER_WIDTH  carrier half-period minus 1, in clocks
- carrier_mod  in  1  1 = marks are modulated by the carrier
- idle_level  in  1  pin level while idle
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- busy  out  1  sequence in progress
- done  out  1  single-cycle pulse on natural completion
- pulse_out  out  1  transmit pin

Behaviour:
- Reset:
  - State is IDLE; busy=0, done=0; idx, loop and tick counters clear.
  - pulse_out follows idle_level.
  - Symbol memory is not reset; contents are undefined until written.
- States: IDLE and RUN only. The memory read is asynchronous, so there is no load state and no gap between symbols.
- IDLE + start, with stop=0 and sym_count!=0:
  - Latch sym_count, loop_count, prescale, carrier_duration and carrier_mod.
  - Set idx=0, loops_left=loop_count, tick counter=prescale, dur counter=mem[0].duration.
  - Enter RUN; busy=1 from the next cycle.
- IDLE + start with sym_count==0: done=1 for one cycle next cycle; remain IDLE.
- Symbol timing in RUN:
  - The tick counter decrements every clock. At 0 it reloads prescale_q, and the dur counter decrements.
  - Each symbol therefore lasts exactly (duration+1)*(prescale_q+1) clocks.
- Symbol end (tick==0 and dur==0):
  - If idx < sym_count_q-1: idx++ and load the next entry in the same edge.
  - Else if loops_left!=0: loops_left--, idx=0, reload mem[0].
  - Else: enter IDLE. done=1 and busy=0 in the following cycle.
- pulse_out:
  - In RUN: level & (~carrier_mod_q | carrier_out). A space outputs 0; an unmodulated mark outputs 1.
  - In IDLE: idle_level.
- Carrier generator:
  - en = RUN & level & carrier_mod_q. Its active-low reset is driven by ~sys_rst.
  - Consecutive marks keep en high, so carrier phase is continuous across them.
  - A space between marks restarts the phase; the output is 0 for the first carrier_duration+1 clocks of a mark.
- stop in RUN: enter IDLE next cycle with no done pulse. stop has priority over symbol end and over start.
- start while RUN is ignored. start and stop in the same IDLE cycle: stay IDLE.
- Memory writes:
  - wr_en while busy is ignored; memory is frozen during playback.
  - wr_en and start in the same IDLE cycle: the write lands and playback sees the new data.
- Latched config is unaffected by input changes during RUN.
- sym_count > DEPTH is clamped to DEPTH.

Decomposition:
- Shared package holds:
  - state encoding (ST_IDLE, ST_RUN);
  - symbol field constants (LEVEL_BIT = DURATION_WIDTH, duration slice);
  - the ADDR_W derivation.
- One sub-module is natural: the existing carrier generator (carrier), instantiated with TIMER_WIDTH, driven from carrier_duration_q.

Test Plan:
- Basic playback:
  - Stimulus: mem[0]={1,2}, mem[1]={0,0}, sym_count=2, prescale=1, mod=0, loop=0, idle_level=0; start at cycle 0.
  - Required: pulse_out=1 for cycles 1-6 and 0 for cycles 7-8; busy high for cycles 1-8; done=1 and busy=0 at cycle 9.
- Loop:
  - Stimulus: mem[0]={1,0}, sym_count=1, prescale=0, loop_count=2.
  - Required: pulse_out high for exactly 3 cycles, then done pulses once.
- Carrier:
  - Stimulus: mem[0]={1,7}, prescale=0, mod=1, carrier_duration=1.
  - Required: pulse_out=0,0,1,1,0,0,1,1 over cycles 1-8, then idle_level.
- Abort:
  - Stimulus: stop asserted 3 cycles into a 20-cycle mark.
  - Required: busy=0 and pulse_out=idle_level next cycle; done never asserts; a new start then plays from idx 0.
- Edge cases:
  - sym_count=0 start: done pulses next cycle and busy stays 0.
  - wr_en during RUN: memory content unchanged on the next playback.
- Reset:
  - Stimulus: sys_rst mid-RUN.
  - Required: busy=0, done=0 and pulse_out=idle_level next cycle; the carrier resets with it.

Source files
------------

// File: rtl/pulse_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_sequencer_pkg
//  Purpose  : Shared definitions for the pulse sequencer: FSM state encoding,
//             symbol field layout helpers and the address-width derivation.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pulse_sequencer_pkg;

  // Sequencer states. Memory reads are asynchronous, so no load state exists.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Symbol memory address width for a given number of entries.
  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  // A symbol is {level, duration}; the level sits just above the duration.
  function automatic int level_bit(input int duration_width);
    return duration_width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_sequencer_carrier.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_sequencer_carrier
//  Purpose  : 50%-duty carrier generator. While enabled, the output toggles
//             every half_period_i+1 clocks, starting low. Dropping the enable
//             returns it to phase zero.
//  Ports    : clk            - clock
//             rst_n_i        - synchronous active-low reset
//             en_i           - run enable; low clears the phase
//             half_period_i  - half period minus one, in clocks
//             carrier_o      - carrier output
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_sequencer_carrier #(
  parameter int TIMER_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic [TIMER_WIDTH-1:0] half_period_i,
  output logic                   carrier_o
);

  logic [TIMER_WIDTH-1:0] count_q;
  logic                   carrier_q;

  always_ff @(posedge clk) begin
    if (!rst_n_i || !en_i) begin
      count_q   <= '0;
      carrier_q <= 1'b0;
    end else if (count_q == half_period_i) begin
      count_q   <= '0;
      carrier_q <= ~carrier_q;
    end else begin
      count_q   <= count_q + 1'b1;
    end
  end

  assign carrier_o = carrier_q;

endmodule
`default_nettype wire

// File: rtl/pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pulse_sequencer
//  Purpose  : Plays a programmed list of {level, duration} symbols on a single
//             pin. Durations count prescaled ticks; marks may be modulated by
//             the carrier generator. The list can repeat loop_count extra times.
//  Ports    : clk, sys_rst           - clock, synchronous active-high reset
//             wr_en/wr_addr/wr_data  - symbol memory write (ignored while busy)
//             sym_count, loop_count  - list length and extra repetitions
//             prescale               - one tick every prescale+1 clocks
//             carrier_duration/_mod  - carrier half period-1, modulation enable
//             idle_level             - pin level while idle
//             start, stop            - single-cycle start / abort requests
//             busy, done             - in progress / natural completion pulse
//             pulse_out              - transmit pin
//  Revision : 1.0 - initial release
// ============================================================================
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter  int TIMER_WIDTH    = 11,
  parameter  int DURATION_WIDTH = 8,
  parameter  int PRESCALE_WIDTH = 8,
  parameter  int DEPTH          = 8,
  localparam int ADDR_W         = addr_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      sys_rst,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DURATION_WIDTH:0]   wr_data,
  input  logic [ADDR_W:0]           sym_count,
  input  logic [7:0]                loop_count,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [TIMER_WIDTH-1:0]    carrier_duration,
  input  logic                      carrier_mod,
  input  logic                      idle_level,
  input  logic                      start,
  input  logic                      stop,
  output logic                      busy,
  output logic                      done,
  output logic                      pulse_out
);

  localparam int LEVEL_BIT = level_bit(DURATION_WIDTH);

  logic [DURATION_WIDTH:0]   mem_q [DEPTH];

  state_e                    state_q;
  logic [ADDR_W-1:0]         idx_q;
  logic [7:0]                loops_left_q;
  logic [PRESCALE_WIDTH-1:0] tick_q;
  logic [DURATION_WIDTH-1:0] dur_q;
  logic [ADDR_W:0]           sym_count_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [TIMER_WIDTH-1:0]    carrier_duration_q;
  logic                      carrier_mod_q;
  logic                      busy_q;
  logic                      done_q;

  logic                      mem_we;
  logic [ADDR_W-1:0]         idx_next;
  logic [ADDR_W:0]           sym_count_clamped;
  logic [DURATION_WIDTH-1:0] first_dur;
  logic                      last_sym;
  logic                      level;
  logic                      carrier_en;
  logic                      carrier_out;

  // Memory is frozen during playback.
  assign mem_we = wr_en && (state_q == ST_IDLE);

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign sym_count_clamped = (sym_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : sym_count;

  // A write to entry 0 in the start cycle must be seen by the first symbol,
  // so the initial duration bypasses the memory in that case.
  assign first_dur = (mem_we && (wr_addr == '0)) ? wr_data[DURATION_WIDTH-1:0]
                                                 : mem_q[0][DURATION_WIDTH-1:0];

  assign idx_next = idx_q + 1'b1;
  assign last_sym = ({1'b0, idx_q} == (sym_count_q - 1'b1));
  assign level    = mem_q[idx_q][LEVEL_BIT];

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q            <= ST_IDLE;
      idx_q              <= '0;
      loops_left_q       <= '0;
      tick_q             <= '0;
      dur_q              <= '0;
      sym_count_q        <= '0;
      prescale_q         <= '0;
      carrier_duration_q <= '0;
      carrier_mod_q      <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            if (sym_count == '0) begin
              done_q <= 1'b1;
            end else begin
              sym_count_q        <= sym_count_clamped;
              prescale_q         <= prescale;
              carrier_duration_q <= carrier_duration;
              carrier_mod_q      <= carrier_mod;
              loops_left_q       <= loop_count;
              idx_q              <= '0;
              tick_q             <= prescale;
              dur_q              <= first_dur;
              state_q            <= ST_RUN;
              busy_q             <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (tick_q != '0) begin
            tick_q <= tick_q - 1'b1;
          end else begin
            tick_q <= prescale_q;
            if (dur_q != '0) begin
              dur_q <= dur_q - 1'b1;
            end else if (!last_sym) begin
              idx_q <= idx_next;
              dur_q <= mem_q[idx_next][DURATION_WIDTH-1:0];
            end else if (loops_left_q != '0) begin
              loops_left_q <= loops_left_q - 1'b1;
              idx_q        <= '0;
              dur_q        <= mem_q[0][DURATION_WIDTH-1:0];
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Enable stays high across back-to-back marks, keeping carrier phase continuous.
  assign carrier_en = (state_q == ST_RUN) && level && carrier_mod_q;

  pulse_sequencer_carrier #(
    .TIMER_WIDTH (TIMER_WIDTH)
  ) u_carrier (
    .clk           (clk),
    .rst_n_i       (~sys_rst),
    .en_i          (carrier_en),
    .half_period_i (carrier_duration_q),
    .carrier_o     (carrier_out)
  );

  assign pulse_out = (state_q == ST_RUN) ? (level & (~carrier_mod_q | carrier_out)) : idle_level;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pulse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pulse_sequencer
//  Purpose  : Self-checking bench for pulse_sequencer: cycle tables for the
//             basic and carrier cases, directed corner sequences, and random
//             programs checked against a waveform model built from the
//             symbol list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_sequencer;

  localparam int TW = 11;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int DEPTH = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW:0]   wr_data = '0;
  logic [AW:0]   sym_count = '0;
  logic [7:0]    loop_count = '0;
  logic [PW-1:0] prescale = '0;
  logic [TW-1:0] carrier_duration = '0;
  logic          carrier_mod = 1'b0;
  logic          idle_level = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy;
  logic          done;
  logic          pulse_out;

  pulse_sequencer #(
    .TIMER_WIDTH(TW), .DURATION_WIDTH(DW), .PRESCALE_WIDTH(PW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .sys_rst(sys_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sym_count(sym_count), .loop_count(loop_count), .prescale(prescale),
    .carrier_duration(carrier_duration), .carrier_mod(carrier_mod),
    .idle_level(idle_level), .start(start), .stop(stop),
    .busy(busy), .done(done), .pulse_out(pulse_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [DW:0] m_mem [DEPTH];
  bit          exp_q [$];

  typedef struct {
    logic start;
    logic stop;
    logic exp_pulse;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [DW:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    m_mem[a] = d;
  endtask

  // Expected pin waveform from the symbol list: each symbol lasts
  // (dur+1)*(prescale+1) clocks; a modulated mark run starts its carrier low
  // and toggles every carrier_duration+1 clocks, restarting after any space.
  function automatic void build_model();
    int n;
    int pos;
    n = (int'(sym_count) > DEPTH) ? DEPTH : int'(sym_count);
    pos = 0;
    exp_q.delete();
    for (int rep = 0; rep <= int'(loop_count); rep++) begin
      for (int s = 0; s < n; s++) begin
        for (int k = 0; k < (int'(m_mem[s][DW-1:0]) + 1) * (int'(prescale) + 1); k++) begin
          if (!m_mem[s][DW]) begin
            exp_q.push_back(1'b0);
            pos = 0;
          end else if (!carrier_mod) begin
            exp_q.push_back(1'b1);
          end else begin
            exp_q.push_back(((pos / (int'(carrier_duration) + 1)) % 2) == 1);
            pos++;
          end
        end
      end
    end
  endfunction

  // Start the current program and check every cycle until done. With noise
  // set, the latched inputs, start and memory writes are scrambled while
  // running; none of that may disturb playback.
  task automatic play_check(input string tag, input bit noise,
                            input bit wr_at_start, input int wa, input logic [DW:0] wd);
    logic [AW:0]   s_sym;
    logic [7:0]    s_loop;
    logic [PW-1:0] s_pre;
    logic [TW-1:0] s_cd;
    logic          s_mod;
    if (wr_at_start) m_mem[wa] = wd;
    build_model();
    s_sym = sym_count; s_loop = loop_count; s_pre = prescale; s_cd = carrier_duration; s_mod = carrier_mod;
    if (wr_at_start) begin
      wr_en = 1'b1; wr_addr = AW'(wa); wr_data = wd;
    end
    start = 1'b1;
    tick();
    start = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      chk($sformatf("%s pulse c%0d", tag, c + 1), pulse_out, exp_q[c]);
      chk($sformatf("%s busy c%0d", tag, c + 1), busy, 1'b1);
      chk($sformatf("%s done c%0d", tag, c + 1), done, 1'b0);
      if (noise) begin
        sym_count = AW'($urandom); loop_count = 8'($urandom); prescale = PW'($urandom);
        carrier_duration = TW'($urandom); carrier_mod = 1'($urandom);
        start = ($urandom_range(0, 3) == 0);
        wr_en = 1'b1; wr_addr = AW'($urandom); wr_data = (DW+1)'($urandom);
      end
      tick();
    end
    start = 1'b0; wr_en = 1'b0;
    sym_count = s_sym; loop_count = s_loop; prescale = s_pre; carrier_duration = s_cd; carrier_mod = s_mod;
    chk({tag, " end busy"}, busy, 1'b0);
    chk({tag, " end done"}, done, 1'b1);
    chk({tag, " end pulse"}, pulse_out, idle_level);
    tick();
    chk({tag, " post done"}, done, 1'b0);
  endtask

  task automatic apply_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start; stop = tbl[i].stop;
      tick();
      start = 1'b0; stop = 1'b0;
      chk($sformatf("%s pulse c%0d", tag, i + 1), pulse_out, tbl[i].exp_pulse);
      chk($sformatf("%s busy c%0d", tag, i + 1), busy, tbl[i].exp_busy);
      chk($sformatf("%s done c%0d", tag, i + 1), done, tbl[i].exp_done);
    end
  endtask

  initial begin
    // ---------------- reset ----------------
    sys_rst = 1'b1; idle_level = 1'b1;
    tick(); tick();
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst pulse idle1", pulse_out, 1'b1);
    idle_level = 1'b0; #1;
    chk("rst pulse idle0", pulse_out, 1'b0);
    sys_rst = 1'b0;
    tick();

    // ---------------- basic playback table ----------------
    write_mem(0, {1'b1, 8'd2});
    write_mem(1, {1'b0, 8'd0});
    sym_count = 4'd2; prescale = 8'd1; carrier_mod = 1'b0; loop_count = 8'd0; idle_level = 1'b0;
    tbl.delete();
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    apply_table("basic");

    // ---------------- carrier table ----------------
    write_mem(0, {1'b1, 8'd7});
    sym_count = 4'd1; prescale = 8'd0; carrier_mod = 1'b1; carrier_duration = 11'd1; idle_level = 1'b1;
    tbl.delete();
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    apply_table("carrier");

    // ---------------- loop ----------------
    write_mem(0, {1'b1, 8'd0});
    sym_count = 4'd1; prescale = 8'd0; loop_count = 8'd2; carrier_mod = 1'b0; idle_level = 1'b0;
    play_check("loop", 1'b0, 1'b0, 0, '0);

    // ---------------- sym_count = 0 ----------------
    sym_count = 4'd0; loop_count = 8'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("zero done", done, 1'b1);
    chk("zero busy", busy, 1'b0);
    tick();
    chk("zero done clr", done, 1'b0);
    chk("zero busy stays", busy, 1'b0);

    // ---------------- start+stop in idle ----------------
    sym_count = 4'd1;
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("st+sp busy", busy, 1'b0);
    chk("st+sp done", done, 1'b0);

    // ---------------- abort ----------------
    write_mem(0, {1'b1, 8'd19});
    write_mem(1, {1'b0, 8'd2});
    sym_count = 4'd2; idle_level = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("abort pre pulse", pulse_out, 1'b1);
    idle_level = 1'b1;
    stop = 1'b1; start = 1'b1; tick(); stop = 1'b0; start = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort pulse", pulse_out, 1'b1);
    idle_level = 1'b0; #1;
    chk("abort pulse idle0", pulse_out, 1'b0);
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < 30; i++) begin
        if (done) saw_done = 1'b1;
        tick();
      end
      chk("abort no done", saw_done, 1'b0);
    end
    play_check("restart", 1'b0, 1'b0, 0, '0);

    // ---------------- writes/config changes during run, then replay ----------------
    write_mem(0, {1'b1, 8'd3});
    write_mem(1, {1'b0, 8'd1});
    write_mem(2, {1'b1, 8'd2});
    sym_count = 4'd3; prescale = 8'd1; loop_count = 8'd1; carrier_mod = 1'b1; carrier_duration = 11'd0;
    play_check("frozen", 1'b1, 1'b0, 0, '0);
    play_check("replay", 1'b0, 1'b0, 0, '0);

    // ---------------- write to entry 0 in the start cycle ----------------
    play_check("wr@start", 1'b0, 1'b1, 0, {1'b1, 8'd5});

    // ---------------- sym_count clamp ----------------
    for (int a = 0; a < DEPTH; a++) write_mem(a, {1'(a), 8'(a % 3)});
    sym_count = 4'd13; loop_count = 8'd0; prescale = 8'd0; carrier_mod = 1'b0;
    play_check("clamp", 1'b0, 1'b0, 0, '0);

    // ---------------- reset mid-run ----------------
    write_mem(0, {1'b1, 8'd30});
    sym_count = 4'd1; carrier_mod = 1'b1; carrier_duration = 11'd2; idle_level = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    sys_rst = 1'b1; tick(); sys_rst = 1'b0;
    chk("midrst busy", busy, 1'b0);
    chk("midrst done", done, 1'b0);
    chk("midrst pulse", pulse_out, 1'b1);
    idle_level = 1'b0;
    play_check("postrst", 1'b0, 1'b0, 0, '0);

    // ---------------- random programs ----------------
    for (int it = 0; it < 30; it++) begin
      for (int a = 0; a < DEPTH; a++) write_mem(a, {1'($urandom), 8'($urandom_range(0, 5))});
      sym_count        = 4'($urandom_range(1, 11));
      loop_count       = 8'($urandom_range(0, 2));
      prescale         = 8'($urandom_range(0, 3));
      carrier_mod      = 1'($urandom);
      carrier_duration = 11'($urandom_range(0, 3));
      idle_level       = 1'($urandom);
      play_check($sformatf("rnd%0d", it), 1'($urandom), 1'b0, 0, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
